// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Command encodings, frame sizes and FSM states for spi_master.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_WAIT_RD = 3'd4,
        ST_RECV    = 3'd5,
        ST_FINISH  = 3'd6
    } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_if
// Description : Host handshake plus SPI pins of spi_master.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_master_if;
    import spi_pkg::*;

    logic                  start;
    logic [FRAME_BITS-1:0] din;
    logic                  busy;
    logic                  done;
    logic [DATA_BITS-1:0]  rd_data;
    logic                  rd_valid;
    logic                  SS_n;
    logic                  MOSI;
    logic                  MISO;

    modport master (
        input  start, din, MISO,
        output busy, done, rd_data, rd_valid, SS_n, MOSI
    );

    modport slave (
        output start, din, MISO,
        input  busy, done, rd_data, rd_valid, SS_n, MOSI
    );

endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : Single-frame SPI master: 10-bit command/payload out, optional
//               8-bit read-back after a fixed slave latency.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master
    import spi_pkg::*;
#(
    parameter int RD_LATENCY = 4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    spi_master_if.master bus
);

    localparam logic [2:0] c_IDLE    = 3'(ST_IDLE);
    localparam logic [2:0] c_SELECT  = 3'(ST_SELECT);
    localparam logic [2:0] c_SHIFT   = 3'(ST_SHIFT);
    localparam logic [2:0] c_HOLD    = 3'(ST_HOLD);
    localparam logic [2:0] c_WAIT_RD = 3'(ST_WAIT_RD);
    localparam logic [2:0] c_RECV    = 3'(ST_RECV);
    localparam logic [2:0] c_FINISH  = 3'(ST_FINISH);

    // Counter loads are "remaining cycles after this one" in the entered state
    localparam logic [4:0] c_SELECT_LOAD = 5'd1;
    localparam logic [4:0] c_SHIFT_LOAD  = 5'(FRAME_BITS - 1);
    localparam logic [4:0] c_WAIT_LOAD   = 5'(RD_LATENCY - 1);
    localparam logic [4:0] c_RECV_LOAD   = 5'(DATA_BITS - 1);

    logic [2:0]            r_state;
    logic [4:0]            r_cnt;
    logic [1:0]            r_cmd;
    logic [FRAME_BITS-1:0] r_sh;
    logic [DATA_BITS-2:0]  r_rx;
    logic [DATA_BITS-1:0]  r_rd_data;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_rd_valid;
    logic                  r_ss_n;
    logic                  r_mosi;

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.SS_n     = r_ss_n;
    assign bus.MOSI     = r_mosi;

    // Outputs are registered one edge ahead: each state drives the next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= 5'd0;
            r_cmd      <= 2'b00;
            r_sh       <= '0;
            r_rx       <= '0;
            r_rd_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_ss_n     <= 1'b1;
            r_mosi     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.start && !r_busy) begin
                        r_state <= c_SELECT;
                        r_cnt   <= c_SELECT_LOAD;
                        r_busy  <= 1'b1;
                        r_ss_n  <= 1'b0;
                        r_mosi  <= bus.din[FRAME_BITS-1];
                        r_sh    <= bus.din;
                        r_cmd   <= bus.din[FRAME_BITS-1:FRAME_BITS-2];
                    end
                end
                c_SELECT: begin
                    r_mosi <= r_sh[FRAME_BITS-1];
                    if (r_cnt != 5'd0) begin
                        r_cnt <= r_cnt - 5'd1;
                    end else begin
                        r_state <= c_SHIFT;
                        r_cnt   <= c_SHIFT_LOAD;
                    end
                end
                c_SHIFT: begin
                    if (r_cnt != 5'd0) begin
                        r_cnt  <= r_cnt - 5'd1;
                        r_mosi <= r_sh[FRAME_BITS-2];
                        r_sh   <= {r_sh[FRAME_BITS-2:0], 1'b0};
                    end else begin
                        r_mosi <= 1'b0;
                        if (r_cmd == CMD_RD_DATA) begin
                            r_state <= c_WAIT_RD;
                            r_cnt   <= c_WAIT_LOAD;
                        end else begin
                            r_state <= c_HOLD;
                            r_cnt   <= 5'd0;
                        end
                    end
                end
                c_HOLD: begin
                    r_state <= c_FINISH;
                    r_ss_n  <= 1'b1;
                    r_done  <= 1'b1;
                end
                c_WAIT_RD: begin
                    if (r_cnt != 5'd0) begin
                        r_cnt <= r_cnt - 5'd1;
                    end else begin
                        r_state <= c_RECV;
                        r_cnt   <= c_RECV_LOAD;
                    end
                end
                c_RECV: begin
                    r_rx <= {r_rx[DATA_BITS-3:0], bus.MISO};
                    if (r_cnt != 5'd0) begin
                        r_cnt <= r_cnt - 5'd1;
                    end else begin
                        r_state    <= c_FINISH;
                        r_ss_n     <= 1'b1;
                        r_done     <= 1'b1;
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= {r_rx, bus.MISO};
                    end
                end
                c_FINISH: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= 5'd0;
                    r_busy  <= 1'b0;
                    r_ss_n  <= 1'b1;
                    r_mosi  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master
// Description : Self-checking bench for spi_master with an SPI slave + RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;
    import spi_pkg::*;

    localparam int L = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_master_if bus ();

    spi_master #(.RD_LATENCY(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int          len;
        logic [39:0] mosi;
        int          gap;
    } frame_t;

    typedef struct {
        logic [9:0] din;
        int         len;
        logic       rv;
        logic [7:0] rd;
    } vec_t;

    frame_t     frames[$];
    int         done_cnt = 0;
    int         rv_cnt   = 0;
    logic [7:0] slv_ram[256];
    logic [7:0] slv_addr = 8'h00;
    logic [7:0] mdl_ram[256];
    logic [7:0] mdl_addr = 8'h00;
    logic [7:0] mdl_rd   = 8'h00;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: MOSI per SS_n-low cycle index (bit k = cycle k)
    function automatic logic [39:0] exp_mosi(input logic [9:0] d);
        logic [39:0] v;
        v    = '0;
        v[1] = d[9];
        v[2] = d[9];
        for (int k = 3; k <= 12; k++) v[k] = d[12-k];
        return v;
    endfunction

    function automatic int exp_len(input logic [9:0] d);
        return (d[9:8] == CMD_RD_DATA) ? 20 + L : 13;
    endfunction

    task automatic mdl_step(input logic [9:0] d);
        case (d[9:8])
            CMD_WR_DATA: mdl_ram[mdl_addr] = d[7:0];
            CMD_RD_DATA: mdl_rd = mdl_ram[mdl_addr];
            default:     mdl_addr = d[7:0];
        endcase
    endtask

    task automatic slave_apply(input logic [39:0] v);
        logic [9:0] p;
        for (int i = 0; i < 10; i++) p[9-i] = v[3+i];
        case (p[9:8])
            CMD_WR_DATA: slv_ram[slv_addr] = p[7:0];
            CMD_RD_DATA: ;
            default:     slv_addr = p[7:0];
        endcase
    endtask

    // Bus monitor and SPI slave: logs MOSI per low cycle, drives MISO
    initial begin : mon
        int          lowcyc;
        int          hi;
        int          cur_gap;
        int          bi;
        logic [39:0] v;
        logic [7:0]  tx;
        lowcyc  = 0;
        hi      = 100;
        cur_gap = 0;
        v       = '0;
        bus.MISO = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
            if (bus.rd_valid === 1'b1) rv_cnt++;
            if (bus.SS_n === 1'b0) begin
                if (lowcyc == 0) begin
                    cur_gap = hi;
                    v       = '0;
                end
                lowcyc++;
                if (lowcyc < 40) v[lowcyc] = bus.MOSI;
                if (v[3] && v[4] && lowcyc >= 13 + L && lowcyc <= 20 + L) begin
                    tx       = slv_ram[slv_addr];
                    bi       = 20 + L - lowcyc;
                    bus.MISO = tx[bi];
                end else begin
                    bus.MISO = 1'b0;
                end
            end else begin
                bus.MISO = 1'b0;
                if (lowcyc != 0) begin
                    frames.push_back('{lowcyc, v, cur_gap});
                    if (lowcyc >= 13) slave_apply(v);
                    lowcyc = 0;
                    hi     = 1;
                end else if (hi < 1000) begin
                    hi++;
                end
            end
        end
    end

    task automatic wait_busy(input logic val, input string nm);
        int n;
        n = 0;
        while (bus.busy !== val && n < 200) begin
            tick();
            n++;
        end
        if (bus.busy !== val) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s.timeout: busy never reached %0b", nm, val);
        end
    endtask

    task automatic check_frame(input string nm, input logic [9:0] d, input int len);
        frame_t f;
        if (frames.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s.frame: no frame seen, expected len %0d", nm, len);
        end else begin
            f = frames.pop_front();
            chk({nm, ".len"}, 64'(f.len), 64'(len));
            chk({nm, ".mosi"}, 64'(f.mosi), 64'(exp_mosi(d)));
        end
    endtask

    // One frame; start re-pulsed at low cycles pa/pb and din scrambled mid-frame
    task automatic send(input logic [9:0] d, input int pa, input int pb, input int len,
                        input logic rv, input logic [7:0] rd, input string nm);
        int n;
        int dc0;
        int rc0;
        wait_busy(1'b0, nm);
        dc0 = done_cnt;
        rc0 = rv_cnt;
        bus.din   = d;
        bus.start = 1'b1;
        tick();
        chk({nm, ".accept"}, {63'd0, bus.busy}, 64'd1);
        n = 1;
        while (bus.done !== 1'b1 && n < 200) begin
            bus.start = (n == pa || n == pb);
            bus.din   = 10'($urandom);
            tick();
            n++;
        end
        bus.start = 1'b0;
        if (bus.done !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s.timeout: done not seen, expected after %0d cycles", nm, len);
        end else begin
            chk({nm, ".ss_n_done"}, {63'd0, bus.SS_n}, 64'd1);
            chk({nm, ".rd_valid"}, {63'd0, bus.rd_valid}, {63'd0, rv});
            chk({nm, ".rd_data"}, {56'd0, bus.rd_data}, {56'd0, rd});
            check_frame(nm, d, len);
            tick();
            chk({nm, ".done_pulses"}, 64'(done_cnt - dc0), 64'd1);
            chk({nm, ".rv_pulses"}, 64'(rv_cnt - rc0), {63'd0, rv});
            chk({nm, ".busy_clear"}, {63'd0, bus.busy}, 64'd0);
        end
    endtask

    vec_t tbl[10];

    initial begin : main
        logic [9:0] d;
        int         dc0;
        for (int i = 0; i < 256; i++) begin
            slv_ram[i] = 8'(i) ^ 8'h3C;
            mdl_ram[i] = 8'(i) ^ 8'h3C;
        end
        bus.start = 1'b0;
        bus.din   = '0;
        rst       = 1'b1;
        repeat (3) tick();
        chk("reset.ss_n", {63'd0, bus.SS_n}, 64'd1);
        chk("reset.mosi", {63'd0, bus.MOSI}, 64'd0);
        chk("reset.busy", {63'd0, bus.busy}, 64'd0);
        chk("reset.done_rv", {62'd0, bus.done, bus.rd_valid}, 64'd0);
        chk("reset.rd_data", {56'd0, bus.rd_data}, 64'd0);
        rst = 1'b0;
        tick();

        tbl[0] = '{10'h0A5, 13,     1'b0, 8'h00};
        tbl[1] = '{10'h012, 13,     1'b0, 8'h00};
        tbl[2] = '{10'h15A, 13,     1'b0, 8'h00};
        tbl[3] = '{10'h212, 13,     1'b0, 8'h00};
        tbl[4] = '{10'h300, 20 + L, 1'b1, 8'h5A};
        tbl[5] = '{10'h040, 13,     1'b0, 8'h5A};
        tbl[6] = '{10'h1C3, 13,     1'b0, 8'h5A};
        tbl[7] = '{10'h3FF, 20 + L, 1'b1, 8'hC3};
        tbl[8] = '{10'h27E, 13,     1'b0, 8'hC3};
        tbl[9] = '{10'h3A0, 20 + L, 1'b1, 8'h42};
        for (int i = 0; i < 10; i++) begin
            mdl_step(tbl[i].din);
            send(tbl[i].din, 0, 0, tbl[i].len, tbl[i].rv, tbl[i].rd, $sformatf("vec%0d", i));
        end

        // start re-pulsed while busy must not launch another frame
        mdl_step(10'h1B4);
        send(10'h1B4, 5, 13, 13, 1'b0, mdl_rd, "busy_ignore");
        repeat (4) tick();
        chk("busy_ignore.no_extra", 64'(frames.size()), 64'd0);
        chk("busy_ignore.ss_n", {63'd0, bus.SS_n}, 64'd1);

        // start held high across two frames
        wait_busy(1'b0, "b2b");
        bus.din   = 10'h1E1;
        bus.start = 1'b1;
        tick();
        bus.din = 10'h2C6;
        wait_busy(1'b0, "b2b");
        tick();
        bus.start = 1'b0;
        bus.din   = 10'h000;
        wait_busy(1'b0, "b2b");
        mdl_step(10'h1E1);
        mdl_step(10'h2C6);
        check_frame("b2b.a", 10'h1E1, 13);
        if (frames.size() != 0) chk("b2b.gap", 64'(frames[0].gap), 64'd2);
        check_frame("b2b.b", 10'h2C6, 13);

        // reset during cycle 7 of a wr-data frame, start held with reset
        wait_busy(1'b0, "rst_mid");
        dc0       = done_cnt;
        bus.din   = 10'h1AB;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid.ss_n", {63'd0, bus.SS_n}, 64'd1);
        chk("rst_mid.mosi", {63'd0, bus.MOSI}, 64'd0);
        chk("rst_mid.busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_mid.done", {63'd0, bus.done}, 64'd0);
        bus.start = 1'b1;
        bus.din   = 10'h0FF;
        tick();
        chk("rst_start.busy", {63'd0, bus.busy}, 64'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (3) tick();
        chk("rst_start.ss_n", {63'd0, bus.SS_n}, 64'd1);
        chk("rst_mid.no_done", 64'(done_cnt - dc0), 64'd0);
        if (frames.size() != 0) begin
            chk("rst_mid.len", 64'(frames[0].len), 64'd7);
            void'(frames.pop_front());
        end
        mdl_rd = 8'h00;

        for (int i = 0; i < 20; i++) begin
            d = 10'($urandom);
            mdl_step(d);
            send(d, 0, 0, exp_len(d), d[9:8] == CMD_RD_DATA, mdl_rd, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: RD_LATENCY, default 4, is the number of SS_n-low cycles between the last MOSI bit and the first MISO sample of a read-data frame (range 1..15).
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rst  input  1  one clock; reset is synchronous and active-high.
REQ-004 start  input  1  request a frame; accepted only when busy=0.
REQ-005 din  input  10  frame word: din[9:8] is the command (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data) and din[7:0] is the payload.
REQ-006 busy  output  1  high from the cycle after acceptance until the cycle after done.
REQ-007 done  output  1  one-cycle pulse when a frame completes.
REQ-008 rd_data  output  8  byte captured from MISO in a read-data frame.
REQ-009 rd_valid  output  1  one-cycle pulse with done, for read-data frames only.
REQ-010 SS_n  output  1  slave select, active-low, registered.
REQ-011 MOSI  output  1  serial data to the slave, MSB first, registered.
REQ-012 MISO  input  1  serial data from the slave, MSB first.

Function
REQ-013 An IDLE-state cycle with start=1 and busy=0 shall latch din and set busy=1 on the next edge.
REQ-014 The frame shall begin on the edge after acceptance: SS_n=0; low cycles are numbered 1..N.
REQ-015 Cycles 1 and 2 shall drive MOSI=din[9] (slave select detect, command check).
REQ-016 Cycles 3..12 shall drive MOSI=din[9]..din[0], one bit per cycle.
REQ-017 Commands 00, 01 and 10 shall hold SS_n low for cycle 13 with MOSI=0, giving N=13.
REQ-018 Command 11 shall drive MOSI=0 and wait during cycles 13..12+RD_LATENCY.
REQ-019 Command 11 shall then sample MISO at the end of cycles 13+RD_LATENCY..20+RD_LATENCY into rd_data[7]..rd_data[0], giving N=20+RD_LATENCY.
REQ-020 In the cycle after cycle N: SS_n=1, done=1, rd_valid=1 for command 11, and rd_data shall update only for command 11.
REQ-021 busy shall clear on the edge after done, so SS_n stays high for at least 2 cycles between frames.
REQ-022 start while busy=1 shall be ignored, with no queuing.
REQ-023 din changes after acceptance shall have no effect on the current frame.
REQ-024 States: IDLE, SELECT (cycles 1-2), SHIFT (10 bits), HOLD (cycle 13, non-rd-data), WAIT_RD, RECV (8 bits), FINISH (done cycle).
REQ-025 Transitions:
- IDLE->SELECT on accept.
- SELECT->SHIFT after 2 cycles.
- SHIFT->HOLD or WAIT_RD after 10 bits.
- HOLD->FINISH.
- WAIT_RD->RECV after RD_LATENCY cycles.
- RECV->FINISH after 8 bits.
- FINISH->IDLE.
REQ-026 A single 5-bit down-counter shall be reloaded on each state entry; it shall never wrap below 0.

Reset
REQ-027 While rst=1 at an edge, the block shall force SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=8'h00, state=IDLE and counter=0.
REQ-028 Reset mid-frame shall abort the frame: SS_n=1 on the next edge, with no done and no rd_valid pulse.
REQ-029 start coincident with rst shall be ignored.

Structure
REQ-030 Shared package spi_pkg shall hold:
- command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
- FRAME_BITS=10 and DATA_BITS=8;
- the master state enum.
REQ-031 The block shall be a single module with no sub-module; the shift register, counter and FSM stay inline.

Verification
REQ-032 Write-address: start with din=10'h0A5 -> SS_n low exactly 13 cycles; MOSI cycles 3..12 = 0,0,1,0,1,0,0,1,0,1; done pulses once; rd_valid stays 0.
REQ-033 Read-data, RD_LATENCY=4, slave model drives 8'hC3 on MISO in cycles 17..24 -> SS_n low 24 cycles; rd_data=8'hC3 with rd_valid=done=1 in cycle 25.
REQ-034 Back-to-back: start held high continuously -> accepted only when busy=0; SS_n high exactly 2 cycles between frames; each frame sends its own latched din.
REQ-035 Reset mid-frame: rst=1 at cycle 7 of a wr-data frame -> next cycle SS_n=1, MOSI=0, busy=0, no done.
REQ-036 Busy ignore: start pulsed at cycles 5 and 13 of a frame -> no extra frame; din changed mid-frame -> MOSI bits unchanged.
REQ-037 End-to-end: SPI slave plus RAM, with wr-addr 0x12, wr-data 0x5A, rd-addr 0x12, rd-data -> rd_data=8'h5A.
